// File: rtl/cw305_reg_mailbox_pkg.sv
// Shared register addresses, STATUS/CTRL bit positions and the STATUS word packer
// for the CW305 host<->target mailbox.
package cw305_reg_mailbox_pkg;

    localparam int unsigned REG_MBOX_TX     = 32'h10;
    localparam int unsigned REG_MBOX_RX     = 32'h11;
    localparam int unsigned REG_MBOX_STATUS = 32'h12;
    localparam int unsigned REG_MBOX_CTRL   = 32'h13;

    localparam int unsigned ST_TX_COUNT = 0;
    localparam int unsigned ST_RX_COUNT = 8;
    localparam int unsigned ST_TX_FULL  = 16;
    localparam int unsigned ST_TX_EMPTY = 17;
    localparam int unsigned ST_RX_FULL  = 18;
    localparam int unsigned ST_RX_EMPTY = 19;
    localparam int unsigned ST_TX_OVF   = 20;
    localparam int unsigned ST_RX_UDF   = 21;

    localparam int unsigned CTRL_IRQ_EN     = 0;
    localparam int unsigned CTRL_FLUSH_TX   = 1;
    localparam int unsigned CTRL_FLUSH_RX   = 2;
    localparam int unsigned CTRL_CLR_STICKY = 3;

    function automatic logic [31:0] pack_status(
        input logic [7:0] tx_cnt,
        input logic [7:0] rx_cnt,
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_full,
        input logic       rx_empty,
        input logic       tx_ovf,
        input logic       rx_udf
    );
        logic [31:0] s;
        s                   = '0;
        s[ST_TX_COUNT +: 8] = tx_cnt;
        s[ST_RX_COUNT +: 8] = rx_cnt;
        s[ST_TX_FULL]       = tx_full;
        s[ST_TX_EMPTY]      = tx_empty;
        s[ST_RX_FULL]       = rx_full;
        s[ST_RX_EMPTY]      = rx_empty;
        s[ST_TX_OVF]        = tx_ovf;
        s[ST_RX_UDF]        = rx_udf;
        return s;
    endfunction

endpackage

// File: rtl/cw305_sync_fifo.sv
// Single-clock word FIFO with occupancy count, full/empty flags and a flush that
// overrides any same-cycle push or pop.
module cw305_sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Empty FIFO presents zero so the head never leaks stale or uninitialised data.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cw305_reg_mailbox.sv
// CW305 register-bus mailbox: host writes TX words byte-wise, reads RX words byte-wise,
// with STATUS, CTRL (irq enable, flushes, sticky clear) and a doorbell interrupt.
module cw305_reg_mailbox
    import cw305_reg_mailbox_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pDATA_WIDTH   = 32,
    parameter int pDEPTH        = 8
) (
    input  logic                                   usb_clk,
    input  logic                                   reset_i,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    output logic [7:0]                             read_data,
    input  logic [7:0]                             write_data,
    input  logic                                   reg_read,
    input  logic                                   reg_write,
    input  logic                                   reg_addrvalid,
    output logic [pDATA_WIDTH-1:0]                 O_tx_data,
    output logic                                   O_tx_valid,
    input  logic                                   I_tx_ready,
    input  logic [pDATA_WIDTH-1:0]                 I_rx_data,
    input  logic                                   I_rx_valid,
    output logic                                   O_rx_ready,
    output logic                                   O_irq
);
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int NB = pDATA_WIDTH / 8;
    localparam int CW = $clog2(pDEPTH) + 1;
    localparam logic [pBYTECNT_SIZE-1:0] LastByte = pBYTECNT_SIZE'(NB - 1);

    logic                   qual_rd, qual_wr;
    logic                   sel_tx, sel_rx, sel_st, sel_ctrl;
    logic                   ctrl_wr, flush_tx, flush_rx, clr_sticky;
    logic [pDATA_WIDTH-1:0] staging_q, staging_d;
    logic                   commit, tx_push, tx_pop, rx_push, rx_pop;
    logic                   rd_last, rd_last_q, rd_rise;
    logic                   tx_ovf_q, rx_udf_q, irq_en_q;
    logic [7:0]             read_data_q, rdata;
    logic [31:0]            status_w;

    logic [pDATA_WIDTH-1:0] tx_head, rx_head;
    logic [CW-1:0]          tx_count, rx_count;
    logic                   tx_full, tx_empty, rx_full, rx_empty;

    assign qual_rd  = reg_addrvalid & reg_read;
    assign qual_wr  = reg_addrvalid & reg_write;
    assign sel_tx   = (reg_address == AW'(REG_MBOX_TX));
    assign sel_rx   = (reg_address == AW'(REG_MBOX_RX));
    assign sel_st   = (reg_address == AW'(REG_MBOX_STATUS));
    assign sel_ctrl = (reg_address == AW'(REG_MBOX_CTRL));

    assign ctrl_wr    = qual_wr & sel_ctrl & (reg_bytecnt == '0);
    assign flush_tx   = ctrl_wr & write_data[CTRL_FLUSH_TX];
    assign flush_rx   = ctrl_wr & write_data[CTRL_FLUSH_RX];
    assign clr_sticky = ctrl_wr & write_data[CTRL_CLR_STICKY];

    // Fullness is judged at cycle start, so a same-cycle TX pop cannot rescue a commit.
    assign tx_push = commit & ~tx_full;
    assign tx_pop  = ~tx_empty & I_tx_ready;
    assign rx_push = I_rx_valid & ~rx_full;

    // Pop on the rising edge of a qualified last-byte read so a held strobe pops once.
    assign rd_last = qual_rd & sel_rx & (reg_bytecnt == LastByte);
    assign rd_rise = rd_last & ~rd_last_q;
    assign rx_pop  = rd_rise & ~rx_empty;

    always_comb begin
        staging_d = staging_q;
        commit    = 1'b0;
        if (qual_wr && sel_tx) begin
            for (int i = 0; i < NB; i++) begin
                if (reg_bytecnt == pBYTECNT_SIZE'(i)) staging_d[i*8 +: 8] = write_data;
            end
            commit = (reg_bytecnt == LastByte);
        end
    end

    assign status_w = pack_status(8'(tx_count), 8'(rx_count), tx_full, tx_empty,
                                  rx_full, rx_empty, tx_ovf_q, rx_udf_q);

    always_comb begin
        rdata = '0;
        if (sel_rx) begin
            for (int i = 0; i < NB; i++) begin
                if (reg_bytecnt == pBYTECNT_SIZE'(i)) rdata = rx_head[i*8 +: 8];
            end
        end else if (sel_st) begin
            for (int i = 0; i < 4; i++) begin
                if (reg_bytecnt == pBYTECNT_SIZE'(i)) rdata = status_w[i*8 +: 8];
            end
        end else if (sel_ctrl && reg_bytecnt == '0) begin
            rdata = {7'b0, irq_en_q};
        end
    end

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            staging_q   <= '0;
            rd_last_q   <= 1'b0;
            read_data_q <= '0;
            irq_en_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rx_udf_q    <= 1'b0;
        end else begin
            staging_q <= staging_d;
            rd_last_q <= rd_last;
            if (qual_rd) read_data_q <= rdata;
            if (ctrl_wr) irq_en_q <= write_data[CTRL_IRQ_EN];
            if (commit && tx_full)        tx_ovf_q <= 1'b1;
            else if (clr_sticky)          tx_ovf_q <= 1'b0;
            if (rd_rise && rx_empty)      rx_udf_q <= 1'b1;
            else if (clr_sticky)          rx_udf_q <= 1'b0;
        end
    end

    cw305_sync_fifo #(
        .Width (pDATA_WIDTH),
        .Depth (pDEPTH)
    ) u_tx_fifo (
        .clk_i   (usb_clk),
        .rst_i   (reset_i),
        .flush_i (flush_tx),
        .push_i  (tx_push),
        .data_i  (staging_d),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    cw305_sync_fifo #(
        .Width (pDATA_WIDTH),
        .Depth (pDEPTH)
    ) u_rx_fifo (
        .clk_i   (usb_clk),
        .rst_i   (reset_i),
        .flush_i (flush_rx),
        .push_i  (rx_push),
        .data_i  (I_rx_data),
        .pop_i   (rx_pop),
        .data_o  (rx_head),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign read_data  = read_data_q;
    assign O_tx_data  = tx_head;
    assign O_tx_valid = ~tx_empty;
    assign O_rx_ready = ~rx_full;
    assign O_irq      = irq_en_q & ~rx_empty;

endmodule

// File: tb/tb_cw305_reg_mailbox.sv
// Scenario bench for cw305_reg_mailbox: scoreboard queues hold expected TX/RX words.
module tb_cw305_reg_mailbox;
    localparam logic [13:0] A_TX   = 14'h10;
    localparam logic [13:0] A_RX   = 14'h11;
    localparam logic [13:0] A_ST   = 14'h12;
    localparam logic [13:0] A_CTRL = 14'h13;

    logic        usb_clk = 1'b0;
    logic        reset_i;
    logic [13:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  read_data;
    logic [7:0]  write_data;
    logic        reg_read, reg_write, reg_addrvalid;
    logic [31:0] O_tx_data;
    logic        O_tx_valid;
    logic        I_tx_ready;
    logic [31:0] I_rx_data;
    logic        I_rx_valid;
    logic        O_rx_ready;
    logic        O_irq;

    int n_pass = 0;
    int n_checks = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];

    always #5 usb_clk = ~usb_clk;

    cw305_reg_mailbox dut (
        .usb_clk       (usb_clk),
        .reset_i       (reset_i),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .read_data     (read_data),
        .write_data    (write_data),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .O_tx_data     (O_tx_data),
        .O_tx_valid    (O_tx_valid),
        .I_tx_ready    (I_tx_ready),
        .I_rx_data     (I_rx_data),
        .I_rx_valid    (I_rx_valid),
        .O_rx_ready    (O_rx_ready),
        .O_irq         (O_irq)
    );

    task automatic step();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic reg_wr(input logic [13:0] a, input int k, input logic [7:0] d);
        reg_address = a; reg_bytecnt = 7'(k); write_data = d;
        reg_addrvalid = 1'b1; reg_write = 1'b1;
        step();
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic reg_rd(input logic [13:0] a, input int k, output logic [7:0] d);
        reg_address = a; reg_bytecnt = 7'(k);
        reg_addrvalid = 1'b1; reg_read = 1'b1;
        step();
        reg_read = 1'b0; reg_addrvalid = 1'b0;
        d = read_data;
        step();
    endtask

    task automatic rd_word(input logic [13:0] a, output logic [31:0] w);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            reg_rd(a, k, b);
            w[k*8 +: 8] = b;
        end
    endtask

    task automatic wr_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) reg_wr(A_TX, k, w[k*8 +: 8]);
    endtask

    task automatic rx_push(input logic [31:0] w);
        I_rx_data = w; I_rx_valid = 1'b1;
        rx_q.push_back(w);
        step();
        I_rx_valid = 1'b0;
    endtask

    task automatic drain_tx();
        logic [31:0] exp;
        while (tx_q.size() > 0) begin
            exp = tx_q.pop_front();
            n_checks++;
            if (O_tx_valid !== 1'b1) $display("FAIL drain_valid: got %b want 1", O_tx_valid);
            else n_pass++;
            n_checks++;
            if (O_tx_data !== exp) $display("FAIL drain_data: got %h want %h", O_tx_data, exp);
            else n_pass++;
            I_tx_ready = 1'b1;
            step();
            I_tx_ready = 1'b0;
        end
        n_checks++;
        if (O_tx_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", O_tx_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (read_data !== 8'h00) $display("FAIL rst_read_data: got %h want 00", read_data);
        else n_pass++;
        n_checks++;
        if (O_tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", O_tx_valid);
        else n_pass++;
        n_checks++;
        if (O_tx_data !== 32'h0) $display("FAIL rst_tx_data: got %h want 0", O_tx_data);
        else n_pass++;
        n_checks++;
        if (O_rx_ready !== 1'b1) $display("FAIL rst_rx_ready: got %b want 1", O_rx_ready);
        else n_pass++;
        n_checks++;
        if (O_irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", O_irq);
        else n_pass++;
    endtask

    task automatic test_tx_basic();
        logic [31:0] st;
        reg_wr(A_TX, 0, 8'h11); reg_wr(A_TX, 1, 8'h22);
        reg_wr(A_TX, 2, 8'h33); reg_wr(A_TX, 3, 8'h44);
        tx_q.push_back(32'h4433_2211);
        n_checks++;
        if (O_tx_valid !== 1'b1) $display("FAIL tx_valid: got %b want 1", O_tx_valid);
        else n_pass++;
        n_checks++;
        if (O_tx_data !== 32'h4433_2211) $display("FAIL tx_data: got %h want 44332211", O_tx_data);
        else n_pass++;
        rd_word(A_ST, st);
        n_checks++;
        if (st[7:0] !== 8'd1) $display("FAIL tx_count1: got %0d want 1", st[7:0]);
        else n_pass++;
        drain_tx();
    endtask

    task automatic test_tx_overflow();
        logic [31:0] st, w;
        for (int i = 0; i < 9; i++) begin
            w = 32'hA0B0_C000 + 32'(i);
            wr_word(w);
            if (i < 8) tx_q.push_back(w);
        end
        rd_word(A_ST, st);
        n_checks++;
        if (st[7:0] !== 8'd8) $display("FAIL ovf_count: got %0d want 8", st[7:0]);
        else n_pass++;
        n_checks++;
        if (st[16] !== 1'b1) $display("FAIL ovf_full: got %b want 1", st[16]);
        else n_pass++;
        n_checks++;
        if (st[20] !== 1'b1) $display("FAIL ovf_flag: got %b want 1", st[20]);
        else n_pass++;
        drain_tx();
        reg_wr(A_CTRL, 0, 8'h08);
        rd_word(A_ST, st);
        n_checks++;
        if (st[20] !== 1'b0) $display("FAIL ovf_clear: got %b want 0", st[20]);
        else n_pass++;
        n_checks++;
        if (st[17] !== 1'b1) $display("FAIL tx_empty: got %b want 1", st[17]);
        else n_pass++;
    endtask

    task automatic test_rx_irq();
        logic [31:0] st, w;
        logic [7:0]  b;
        reg_wr(A_CTRL, 0, 8'h01);
        reg_rd(A_CTRL, 0, b);
        n_checks++;
        if (b !== 8'h01) $display("FAIL ctrl_readback: got %h want 01", b);
        else n_pass++;
        rx_push(32'hDEAD_BEEF);
        n_checks++;
        if (O_irq !== 1'b1) $display("FAIL irq_set: got %b want 1", O_irq);
        else n_pass++;
        w = rx_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            reg_rd(A_RX, k, b);
            n_checks++;
            if (b !== w[k*8 +: 8]) $display("FAIL rx_byte%0d: got %h want %h", k, b, w[k*8 +: 8]);
            else n_pass++;
        end
        n_checks++;
        if (O_irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", O_irq);
        else n_pass++;
        rd_word(A_ST, st);
        n_checks++;
        if (st[19] !== 1'b1) $display("FAIL rx_empty: got %b want 1", st[19]);
        else n_pass++;
        reg_wr(A_CTRL, 0, 8'h00);
    endtask

    task automatic test_held_read();
        logic [31:0] st, w, exp;
        logic [7:0]  b;
        rx_push(32'h0102_0304);
        rx_push(32'h0A0B_0C0D);
        exp = rx_q.pop_front();
        reg_address = A_RX; reg_bytecnt = 7'd3; reg_addrvalid = 1'b1; reg_read = 1'b1;
        step();
        b = read_data;
        step();
        step();
        reg_read = 1'b0; reg_addrvalid = 1'b0;
        step();
        n_checks++;
        if (b !== exp[31:24]) $display("FAIL held_byte: got %h want %h", b, exp[31:24]);
        else n_pass++;
        rd_word(A_ST, st);
        n_checks++;
        if (st[15:8] !== 8'd1) $display("FAIL held_count: got %0d want 1", st[15:8]);
        else n_pass++;
        rd_word(A_RX, w);
        exp = rx_q.pop_front();
        n_checks++;
        if (w !== exp) $display("FAIL held_next: got %h want %h", w, exp);
        else n_pass++;
    endtask

    task automatic test_rx_underflow();
        logic [31:0] st;
        logic [7:0]  b;
        reg_rd(A_RX, 3, b);
        n_checks++;
        if (b !== 8'h00) $display("FAIL udf_data: got %h want 00", b);
        else n_pass++;
        rd_word(A_ST, st);
        n_checks++;
        if (st[21] !== 1'b1) $display("FAIL udf_flag: got %b want 1", st[21]);
        else n_pass++;
        n_checks++;
        if (st[15:8] !== 8'd0) $display("FAIL udf_count: got %0d want 0", st[15:8]);
        else n_pass++;
        reg_wr(A_CTRL, 0, 8'h08);
        rd_word(A_ST, st);
        n_checks++;
        if (st[21] !== 1'b0) $display("FAIL udf_clear: got %b want 0", st[21]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] st, w, exp;
        logic [7:0]  b;
        rx_push(32'h1111_2222);
        exp = rx_q.pop_front();
        rx_q.push_back(32'h3333_4444);
        I_rx_data = 32'h3333_4444; I_rx_valid = 1'b1;
        reg_address = A_RX; reg_bytecnt = 7'd3; reg_addrvalid = 1'b1; reg_read = 1'b1;
        step();
        b = read_data;
        I_rx_valid = 1'b0; reg_read = 1'b0; reg_addrvalid = 1'b0;
        step();
        n_checks++;
        if (b !== exp[31:24]) $display("FAIL b2b_byte: got %h want %h", b, exp[31:24]);
        else n_pass++;
        rd_word(A_ST, st);
        n_checks++;
        if (st[15:8] !== 8'd1) $display("FAIL b2b_count: got %0d want 1", st[15:8]);
        else n_pass++;
        rd_word(A_RX, w);
        exp = rx_q.pop_front();
        n_checks++;
        if (w !== exp) $display("FAIL b2b_word: got %h want %h", w, exp);
        else n_pass++;
    endtask

    task automatic test_rx_flush();
        logic [31:0] st;
        for (int i = 0; i < 8; i++) rx_push(32'h5000_0000 + 32'(i));
        n_checks++;
        if (O_rx_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", O_rx_ready);
        else n_pass++;
        rd_word(A_ST, st);
        n_checks++;
        if (st[15:8] !== 8'd8 || st[18] !== 1'b1)
            $display("FAIL rx_full: got count %0d full %b want 8 1", st[15:8], st[18]);
        else n_pass++;
        I_rx_data = 32'hFFFF_FFFF; I_rx_valid = 1'b1;
        reg_wr(A_CTRL, 0, 8'h04);
        I_rx_valid = 1'b0;
        n_checks++;
        if (O_rx_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", O_rx_ready);
        else n_pass++;
        rd_word(A_ST, st);
        n_checks++;
        if (st[15:8] !== 8'd0) $display("FAIL flush_count: got %0d want 0", st[15:8]);
        else n_pass++;
        // Partly filled FIFO: the flush must also beat a push that could otherwise land.
        rx_push(32'h7777_7777);
        I_rx_data = 32'h8888_8888; I_rx_valid = 1'b1;
        reg_wr(A_CTRL, 0, 8'h04);
        I_rx_valid = 1'b0;
        rd_word(A_ST, st);
        n_checks++;
        if (st[15:8] !== 8'd0) $display("FAIL flush_push: got %0d want 0", st[15:8]);
        else n_pass++;
        rx_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        reg_wr(A_CTRL, 0, 8'h01);
        rx_push(32'h0000_0055);
        reg_wr(A_TX, 0, 8'hAA);
        reg_wr(A_TX, 1, 8'hBB);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        rx_q.delete();
        test_reset();
        reg_rd(A_CTRL, 0, b);
        n_checks++;
        if (b !== 8'h00) $display("FAIL rst_irq_en: got %h want 00", b);
        else n_pass++;
        reg_wr(A_TX, 3, 8'h99);
        n_checks++;
        if (O_tx_data !== 32'h9900_0000) $display("FAIL rst_staging: got %h want 99000000", O_tx_data);
        else n_pass++;
        reg_wr(A_CTRL, 0, 8'h02);
        wr_word(32'h0403_0201);
        tx_q.push_back(32'h0403_0201);
        drain_tx();
    endtask

    initial begin
        reset_i = 1'b1; reg_address = '0; reg_bytecnt = '0; write_data = '0;
        reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
        I_tx_ready = 1'b0; I_rx_data = '0; I_rx_valid = 1'b0;
        repeat (3) @(posedge usb_clk);
        #1;
        reset_i = 1'b0;
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_irq();
        test_held_read();
        test_rx_underflow();
        test_back_to_back();
        test_rx_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
